// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the game-state FSM and the tick scheduler.
//   gameon        : level, play state active (master -> scheduler)
//   collision     : one-cycle pulse, player hit (master -> scheduler)
//   game_reset    : one-cycle pulse, clear score and idle (master -> scheduler)
//   score_tick    : one-cycle pulse per score point (scheduler -> master)
//   obstacle_tick : one-cycle pulse requesting an obstacle spawn (scheduler -> master)
//   score_bcd     : 4 BCD digits, [15:12] = thousands (scheduler -> master)
//   level         : current speed level (scheduler -> master)
//   running       : high while in RUN (scheduler -> master)
interface game_tick_scheduler_if;
  logic        gameon;
  logic        collision;
  logic        game_reset;
  logic        score_tick;
  logic        obstacle_tick;
  logic [15:0] score_bcd;
  logic [2:0]  level;
  logic        running;

  modport master (
    output gameon, collision, game_reset,
    input  score_tick, obstacle_tick, score_bcd, level, running
  );

  modport slave (
    input  gameon, collision, game_reset,
    output score_tick, obstacle_tick, score_bcd, level, running
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Gameplay timing for the dino game. A run/pause/over FSM gates a single tick
// divider whose period shrinks as the level rises. Each score point emits a
// score_tick pulse and bumps a saturating 4-digit BCD score; obstacle_tick is
// scheduled every MIN_GAP + lfsr[GAP_BITS-1:0] score points.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : control inputs and registered status outputs (slave side)
module game_tick_scheduler #(
  parameter int unsigned SCORE_DIV  = 3000000,
  parameter int unsigned DIV_DEC    = 250000,
  parameter int unsigned LEVEL_STEP = 100,
  parameter int unsigned MAX_LEVEL  = 7,
  parameter int unsigned MIN_GAP    = 8,
  parameter int unsigned GAP_BITS   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  game_tick_scheduler_if.slave bus
);

  localparam int unsigned CntW = $clog2(SCORE_DIV);
  localparam int unsigned LvlW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  // Wide enough for the largest reload value MIN_GAP + 2**GAP_BITS - 1.
  localparam int unsigned GapW = $clog2(MIN_GAP + (2 ** GAP_BITS));

  typedef enum logic [1:0] {StIdle, StRun, StPause, StOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     score_q, score_d;
  logic [2:0]      level_q, level_d;
  logic [LvlW-1:0] level_cnt_q, level_cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            score_tick_q, score_tick_d;
  logic            obstacle_tick_q, obstacle_tick_d;
  logic            running_q, running_d;

  logic [31:0] period;
  logic        terminal;

  assign period   = SCORE_DIV - DIV_DEC * 32'(level_q);
  assign terminal = (32'(cnt_q) == period - 32'd1);

  // BCD +1 with per-digit carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    score_d         = score_q;
    level_d         = level_q;
    level_cnt_d     = level_cnt_q;
    gap_d           = gap_q;
    score_tick_d    = 1'b0;
    obstacle_tick_d = 1'b0;
    lfsr_d          = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Score lags the tick by one cycle so the new value follows the pulse.
    if (score_tick_q) begin
      score_d = bcd_inc(score_q);
    end

    if (bus.game_reset) begin
      state_d     = StIdle;
      cnt_d       = '0;
      score_d     = '0;
      level_d     = '0;
      level_cnt_d = '0;
      gap_d       = GapW'(MIN_GAP);
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (bus.gameon) state_d = StRun;
        end
        StRun: begin
          if (bus.collision) begin
            state_d = StOver;
          end else if (!bus.gameon) begin
            // Counter holds, even at P-1; the tick fires after resuming.
            state_d = StPause;
          end else if (terminal) begin
            cnt_d        = '0;
            score_tick_d = 1'b1;
            if (32'(level_cnt_q) == LEVEL_STEP - 1) begin
              level_cnt_d = '0;
              if (32'(level_q) < MAX_LEVEL) level_d = level_q + 3'd1;
            end else begin
              level_cnt_d = level_cnt_q + LvlW'(1);
            end
            if (gap_q == GapW'(1)) begin
              obstacle_tick_d = 1'b1;
              gap_d = GapW'(MIN_GAP) + GapW'(lfsr_q[GAP_BITS-1:0]);
            end else begin
              gap_d = gap_q - GapW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPause: begin
          if (bus.collision) begin
            state_d = StOver;
          end else if (bus.gameon) begin
            state_d = StRun;
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      score_q         <= '0;
      level_q         <= '0;
      level_cnt_q     <= '0;
      gap_q           <= GapW'(MIN_GAP);
      lfsr_q          <= 16'hACE1;
      score_tick_q    <= 1'b0;
      obstacle_tick_q <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      score_q         <= score_d;
      level_q         <= level_d;
      level_cnt_q     <= level_cnt_d;
      gap_q           <= gap_d;
      lfsr_q          <= lfsr_d;
      score_tick_q    <= score_tick_d;
      obstacle_tick_q <= obstacle_tick_d;
      running_q       <= running_d;
    end
  end

  assign bus.score_tick    = score_tick_q;
  assign bus.obstacle_tick = obstacle_tick_q;
  assign bus.score_bcd     = score_q;
  assign bus.level         = level_q;
  assign bus.running       = running_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a short period (20 cycles,
// -2 per level, 4 points per level, max level 3, obstacle gap 2..5).
module tb_game_tick_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .SCORE_DIV (20),
    .DIV_DEC   (2),
    .LEVEL_STEP(4),
    .MAX_LEVEL (3),
    .MIN_GAP   (2),
    .GAP_BITS  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles (negedges) until score_tick is seen; -1 if the budget runs out.
  task automatic wait_tick(input int budget, output int n);
    bit found;
    found = 1'b0;
    n     = 0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.score_tick) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  // Next tick after exp_gap cycles, then the score one cycle later.
  task automatic tick_and_score(input int k, input int exp_gap, input logic [15:0] exp_score);
    int n;
    wait_tick(100, n);
    check_eq($sformatf("gap_t%0d", k), n, exp_gap);
    @(negedge clk);
    check_eq($sformatf("score_t%0d", k), bus.score_bcd, exp_score);
  endtask

  // Obstacle monitor: first obstacle on the 2nd tick, later gaps in 2..5.
  logic mon_en = 1'b0;
  int   tick_idx;
  int   last_obs;
  always @(negedge clk) begin
    if (!mon_en) begin
      tick_idx = 0;
      last_obs = 0;
    end else begin
      if (bus.obstacle_tick) check_eq("obs_with_score", bus.score_tick, 1);
      if (bus.score_tick) begin
        tick_idx++;
        if (bus.obstacle_tick) begin
          if (last_obs == 0) check_eq("obs_first_tick", tick_idx, 2);
          else check_eq("obs_gap_range",
                        (tick_idx - last_obs >= 2) && (tick_idx - last_obs <= 5), 1);
          last_obs = tick_idx;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int exp_gap;
    bus.gameon     = 1'b0;
    bus.collision  = 1'b0;
    bus.game_reset = 1'b0;
    rst_n          = 1'b0;
    mon_en         = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_score", bus.score_bcd, 16'h0000);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_running", bus.running, 0);
    check_eq("rst_score_tick", bus.score_tick, 0);
    check_eq("rst_obstacle_tick", bus.obstacle_tick, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_running", bus.running, 0);

    // Start: running next cycle, first tick 20 cycles after the transition.
    bus.gameon = 1'b1;
    @(negedge clk);
    check_eq("run_running", bus.running, 1);
    wait_tick(50, n);
    check_eq("first_tick_cycles", n, 20);
    check_eq("score_still_old", bus.score_bcd, 16'h0000);
    check_eq("no_obs_tick1", bus.obstacle_tick, 0);
    @(negedge clk);
    check_eq("score_t1", bus.score_bcd, 16'h0001);

    // Period 20/18/16/14 for levels 0..3; gap counts exclude the score cycle.
    for (int k = 2; k <= 17; k++) begin
      if (k <= 4) exp_gap = 19;
      else if (k <= 8) exp_gap = 17;
      else if (k <= 12) exp_gap = 15;
      else exp_gap = 13;
      tick_and_score(k, exp_gap, 16'(((k / 10) << 4) | (k % 10)));
      if (k == 4) check_eq("level_after_4", bus.level, 1);
      if (k == 8) check_eq("level_after_8", bus.level, 2);
      if (k == 16) check_eq("level_after_16", bus.level, 3);
    end

    // Pause with counter at 6 of 14: frozen, then 8 more counts on resume.
    repeat (5) @(negedge clk);
    bus.gameon = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.score_tick) cnt++;
    end
    check_eq("pause_no_ticks", cnt, 0);
    check_eq("pause_running", bus.running, 0);
    check_eq("pause_score", bus.score_bcd, 16'h0017);
    bus.gameon = 1'b1;
    wait_tick(50, n);
    check_eq("resume_tick_cycles", n, 9);
    @(negedge clk);
    check_eq("resume_score", bus.score_bcd, 16'h0018);

    // Collision on the terminal cycle (counter 13): no tick, go to OVER.
    repeat (12) @(negedge clk);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    check_eq("coll_no_tick", bus.score_tick, 0);
    check_eq("coll_over", bus.running, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.score_tick) cnt++;
    end
    check_eq("over_no_ticks", cnt, 0);
    check_eq("over_score", bus.score_bcd, 16'h0018);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("over_ignores", bus.running, 0);

    mon_en         = 1'b0;
    bus.gameon     = 1'b0;
    bus.game_reset = 1'b1;
    @(negedge clk);
    bus.game_reset = 1'b0;
    check_eq("greset_score", bus.score_bcd, 16'h0000);
    check_eq("greset_level", bus.level, 0);
    check_eq("greset_running", bus.running, 0);
    @(negedge clk);
    check_eq("greset_idle", bus.running, 0);

    // Long run for BCD carries across digits.
    mon_en     = 1'b1;
    bus.gameon = 1'b1;
    @(negedge clk);
    check_eq("rerun_running", bus.running, 1);
    for (int k = 1; k <= 1000; k++) begin
      wait_tick(100, n);
      if (n < 0) begin
        check_eq("long_run_timeout", n, 0);
        break;
      end
      @(negedge clk);
      if (k == 99) check_eq("bcd_0099", bus.score_bcd, 16'h0099);
      if (k == 100) check_eq("bcd_0100", bus.score_bcd, 16'h0100);
      if (k == 999) check_eq("bcd_0999", bus.score_bcd, 16'h0999);
      if (k == 1000) check_eq("bcd_1000", bus.score_bcd, 16'h1000);
    end

    // Preload 9998 while paused, then saturate.
    bus.gameon = 1'b0;
    repeat (3) @(negedge clk);
    force dut.score_q = 16'h9998;
    @(negedge clk);
    release dut.score_q;
    @(negedge clk);
    check_eq("preload_9998", bus.score_bcd, 16'h9998);
    bus.gameon = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(100, n);
      check_eq($sformatf("sat_tick_seen_%0d", k), n > 0, 1);
      @(negedge clk);
      check_eq($sformatf("sat_score_%0d", k), bus.score_bcd, 16'h9999);
    end
    check_eq("sat_level", bus.level, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
